// File: rtl/div_unit_32b.sv
// div_unit_32b: sequential 32-bit signed restoring divider (DIV -> LO/HI).
// Each CALC cycle performs one trial subtraction of the divisor magnitude
// from the shifted partial remainder; FIX applies the operand signs.
// Quotient truncates toward zero and the remainder takes the dividend's sign.
module div_unit_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;          // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d;          // divisor magnitude
  logic [WIDTH:0]   r;          // partial remainder, one guard bit
  logic [CW-1:0]    count;
  logic             sign_a;     // dividend negative
  logic             sign_b;     // divisor negative

  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;
  logic             accept;

  // Magnitudes of the operands; -2^31 maps onto 0x80000000, which is its
  // correct unsigned magnitude, so the most-negative value needs no special case.
  assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // One restoring step: bring in the next dividend bit, then try subtracting.
  // The remainder is always below D, so R[31:0] carries all of it.
  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d};

  // Sign correction applied in FIX.
  assign q_fixed = (sign_a ^ sign_b) ? -q : q;
  assign r_fixed = sign_a ? -r[WIDTH-1:0] : r[WIDTH-1:0];

  assign accept = start && ((state == IDLE) || (state == DONE));

  // Control FSM and datapath registers; all outputs are registered here.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would chain q/r updates within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      count       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless reloaded below
      done <= 1'b0;
      if (accept) begin
        if (divisor == '0) begin
          // Zero divisor: report immediately, never enter CALC.
          state       <= DONE;
          done        <= 1'b1;
          busy        <= 1'b0;
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          state  <= CALC;
          busy   <= 1'b1;
          q      <= dividend_abs;
          d      <= divisor_abs;
          r      <= '0;
          count  <= '0;
          sign_a <= dividend[WIDTH-1];
          sign_b <= divisor[WIDTH-1];
        end
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          CALC: begin
            if (!trial[WIDTH]) begin
              r <= trial;
              q <= {q[WIDTH-2:0], 1'b1};
            end else begin
              r <= shifted;
              q <= {q[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == LAST_STEP) state <= FIX;
          end
          FIX: begin
            quotient    <= q_fixed;
            remainder   <= r_fixed;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
